inst_issue_seq: RTL and testbench

INST_ISSUE_SEQ -- requirements
Module: inst_issue_seq

---
 rtl/inst_issue_seq.sv | 123 ++++++++++++
 tb/tb_inst_issue_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/inst_issue_seq.sv
// Instruction issue sequencer: streams a small writable program memory to a
// downstream decoder under a valid/ready handshake, one run per start request.
module inst_issue_seq #(
  parameter int unsigned NUM_INSTR  = 4,
  parameter logic [16:0] NOP_OPCODE = 17'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ready,
  input  logic        prog_we,
  input  logic [1:0]  prog_addr,
  input  logic [16:0] prog_data,
  output logic [16:0] opcode,
  output logic [1:0]  pc_count,
  output logic        valid,
  output logic        busy,
  output logic        done
);

  localparam int unsigned OPW   = 17;
  localparam int unsigned PCW   = 2;
  localparam int unsigned DEPTH = 4;
  localparam logic [PCW-1:0] LAST_PC = PCW'(NUM_INSTR - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PCW-1:0]   pc_q, pc_d;
  logic [OPW-1:0]   opcode_q, opcode_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [OPW-1:0]   mem_q [DEPTH];
  logic             mem_we_c;

  // Program memory is only writable while no run is in flight.
  assign mem_we_c = prog_we && (state_q != ISSUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= 17'd5;
      mem_q[1] <= 17'd6;
      mem_q[2] <= 17'd7;
      mem_q[3] <= 17'd4;
    end else if (mem_we_c) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      opcode_q <= NOP_OPCODE;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; every output register holds unless a transition fires.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = done_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = ISSUE;
          pc_d     = '0;
          opcode_d = mem_q[0];
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      ISSUE: begin
        if (valid_q && ready) begin
          if (pc_q == LAST_PC) begin
            state_d  = DONE;
            valid_d  = 1'b0;
            opcode_d = NOP_OPCODE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            pc_d     = pc_q + 2'd1;
            opcode_d = mem_q[pc_q + 2'd1];
          end
        end
      end
      default: begin
        state_d  = IDLE;
        pc_d     = '0;
        opcode_d = NOP_OPCODE;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
      end
    endcase
  end

  assign opcode   = opcode_q;
  assign pc_count = pc_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_inst_issue_seq.sv
// Directed bench for inst_issue_seq: default 4-entry run plus a 1-entry instance.
module tb_inst_issue_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, ready = 1'b0, prog_we = 1'b0;
  logic [1:0]  prog_addr = 2'd0;
  logic [16:0] prog_data = 17'd0;
  logic [16:0] opcode;
  logic [1:0]  pc_count;
  logic        valid, busy, done;

  logic        start1 = 1'b0, ready1 = 1'b0, prog_we1 = 1'b0;
  logic [16:0] opcode1;
  logic [1:0]  pc_count1;
  logic        valid1, busy1, done1;

  int total = 0;
  int bad   = 0;

  inst_issue_seq dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .opcode(opcode), .pc_count(pc_count), .valid(valid), .busy(busy), .done(done)
  );

  inst_issue_seq #(.NUM_INSTR(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .ready(ready1),
    .prog_we(prog_we1), .prog_addr(prog_addr), .prog_data(prog_data),
    .opcode(opcode1), .pc_count(pc_count1), .valid(valid1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [16:0] op, input logic [1:0] pc,
                            input logic v, input logic b, input logic d);
    chk({tag, ".opcode"}, 32'(opcode), 32'(op));
    chk({tag, ".pc"},     32'(pc_count), 32'(pc));
    chk({tag, ".valid"},  32'(valid), 32'(v));
    chk({tag, ".busy"},   32'(busy), 32'(b));
    chk({tag, ".done"},   32'(done), 32'(d));
  endtask

  task automatic expect_idle_done(input string tag, input logic d);
    chk({tag, ".opcode"}, 32'(opcode), 32'd0);
    chk({tag, ".valid"},  32'(valid), 32'd0);
    chk({tag, ".busy"},   32'(busy), 32'd0);
    chk({tag, ".done"},   32'(done), 32'(d));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #2;
    expect_out("reset", 17'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    expect_out("idle", 17'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Basic run with ready held high.
    start = 1'b1; ready = 1'b1;
    tick(); expect_out("run1_0", 17'd5, 2'd0, 1'b1, 1'b1, 1'b0);
    start = 1'b0;
    tick(); expect_out("run1_1", 17'd6, 2'd1, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("run1_2", 17'd7, 2'd2, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("run1_3", 17'd4, 2'd3, 1'b1, 1'b1, 1'b0);
    tick(); expect_idle_done("run1_done", 1'b1);
    tick(); expect_idle_done("run1_hold", 1'b1);

    // Restart from DONE, stall at pc 1 for three cycles with start ignored.
    start = 1'b1;
    tick(); expect_out("run2_0", 17'd5, 2'd0, 1'b1, 1'b1, 1'b0);
    start = 1'b0;
    tick(); expect_out("run2_1", 17'd6, 2'd1, 1'b1, 1'b1, 1'b0);
    ready = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out("stall", 17'd6, 2'd1, 1'b1, 1'b1, 1'b0);
    end
    ready = 1'b1; start = 1'b0;
    tick(); expect_out("run2_2", 17'd7, 2'd2, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("run2_3", 17'd4, 2'd3, 1'b1, 1'b1, 1'b0);
    tick(); expect_idle_done("run2_done", 1'b1);

    // Program write in DONE, then a write attempt during ISSUE.
    prog_we = 1'b1; prog_addr = 2'd2; prog_data = 17'd9;
    tick(); expect_idle_done("wr_done", 1'b1);
    prog_we = 1'b0; start = 1'b1;
    tick(); expect_out("run3_0", 17'd5, 2'd0, 1'b1, 1'b1, 1'b0);
    start = 1'b0; prog_we = 1'b1; prog_addr = 2'd2; prog_data = 17'h1234;
    tick(); expect_out("run3_1", 17'd6, 2'd1, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("run3_2", 17'd9, 2'd2, 1'b1, 1'b1, 1'b0);
    prog_we = 1'b0;
    tick(); expect_out("run3_3", 17'd4, 2'd3, 1'b1, 1'b1, 1'b0);
    tick(); expect_idle_done("run3_done", 1'b1);
    start = 1'b1;
    tick(); expect_out("run4_0", 17'd5, 2'd0, 1'b1, 1'b1, 1'b0);
    start = 1'b0;
    tick(); expect_out("run4_1", 17'd6, 2'd1, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("run4_2", 17'd9, 2'd2, 1'b1, 1'b1, 1'b0);

    // Mid-run reset takes effect without a clock edge and restores memory.
    #2 rst = 1'b1;
    #1;
    expect_out("midrst", 17'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("midrst_hold", 17'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); expect_out("postrst_idle", 17'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick(); expect_out("run5_0", 17'd5, 2'd0, 1'b1, 1'b1, 1'b0);
    start = 1'b0;
    tick(); expect_out("run5_1", 17'd6, 2'd1, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("run5_2", 17'd7, 2'd2, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("run5_3", 17'd4, 2'd3, 1'b1, 1'b1, 1'b0);
    tick(); expect_idle_done("run5_done", 1'b1);

    // Write and start together in DONE: issue sees the old entry 0.
    prog_we = 1'b1; prog_addr = 2'd0; prog_data = 17'h11; start = 1'b1;
    tick(); expect_out("wrstart_0", 17'd5, 2'd0, 1'b1, 1'b1, 1'b0);
    prog_we = 1'b0; start = 1'b0;
    tick(); tick(); tick();
    tick(); expect_idle_done("wrstart_done", 1'b1);
    start = 1'b1;
    tick(); expect_out("run6_0", 17'h11, 2'd0, 1'b1, 1'b1, 1'b0);
    start = 1'b0; ready = 1'b0;

    // Single-entry instance.
    chk("n1_idle.valid", 32'(valid1), 32'd0);
    start1 = 1'b1; ready1 = 1'b1;
    tick();
    chk("n1_0.opcode", 32'(opcode1), 32'd5);
    chk("n1_0.valid", 32'(valid1), 32'd1);
    chk("n1_0.pc", 32'(pc_count1), 32'd0);
    start1 = 1'b0;
    tick();
    chk("n1_done.done", 32'(done1), 32'd1);
    chk("n1_done.valid", 32'(valid1), 32'd0);
    chk("n1_done.opcode", 32'(opcode1), 32'd0);
    chk("n1_done.busy", 32'(busy1), 32'd0);
    start1 = 1'b1;
    tick();
    chk("n1_re.opcode", 32'(opcode1), 32'd5);
    chk("n1_re.valid", 32'(valid1), 32'd1);
    chk("n1_re.done", 32'(done1), 32'd0);
    start1 = 1'b0;
    tick();
    chk("n1_re_done.done", 32'(done1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
